// File: rtl/python_transmitter_10bit.sv
`default_nettype none
// ============================================================================
// Module   : python_transmitter_10bit
// Brief    : PYTHON-style 10-bit word framer: AXI4-Stream pixels -> data lanes
//            plus sync lane with FS/LS/IMG/LE/FE codes, per-lane CRC and TR gaps.
// Revision : 1.0 - initial release
// ============================================================================
module python_transmitter_10bit #(
    parameter int         CHANNELS    = 4,
    parameter int         WIDTH_BITS  = 12,
    parameter int         HEIGHT_BITS = 12,
    parameter int         GAP_BITS    = 8,
    parameter logic [9:0] CODE_FS     = 10'h2AA,
    parameter logic [9:0] CODE_FE     = 10'h3AA,
    parameter logic [9:0] CODE_LS     = 10'h0AA,
    parameter logic [9:0] CODE_LE     = 10'h12A,
    parameter logic [9:0] CODE_IMG    = 10'h035,
    parameter logic [9:0] CODE_CRC    = 10'h059,
    parameter logic [9:0] CODE_TR     = 10'h3A6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH_BITS-1:0]    param_width,
    input  logic [HEIGHT_BITS-1:0]   param_height,
    input  logic [GAP_BITS-1:0]      param_gap,
    input  logic                     s_tuser,
    input  logic                     s_tlast,
    input  logic [CHANNELS*10-1:0]   s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     err_clear,
    output logic [CHANNELS*10-1:0]   out_data,
    output logic [9:0]               out_sync,
    output logic                     underflow,
    output logic                     err_length
);

    localparam int                     c_DW     = CHANNELS * 10;
    localparam logic [c_DW-1:0]        c_TR_ALL = {CHANNELS{CODE_TR}};
    localparam logic [WIDTH_BITS-1:0]  c_W_ONE  = WIDTH_BITS'(1);
    localparam logic [WIDTH_BITS-1:0]  c_W_TWO  = WIDTH_BITS'(2);
    localparam logic [HEIGHT_BITS-1:0] c_H_ONE  = HEIGHT_BITS'(1);
    localparam logic [GAP_BITS-1:0]    c_G_ONE  = GAP_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LINE = 2'd1,
        ST_CRC  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_ready;
    logic [WIDTH_BITS-1:0]    r_col;
    logic [HEIGHT_BITS-1:0]   r_line;
    logic [WIDTH_BITS-1:0]    r_width;
    logic [HEIGHT_BITS-1:0]   r_height;
    logic [GAP_BITS-1:0]      r_gap;
    logic [GAP_BITS-1:0]      r_gap_cnt;
    logic [c_DW-1:0]          r_sum;
    logic [c_DW-1:0]          r_out_data;
    logic [9:0]               r_out_sync;
    logic                     r_underflow;
    logic                     r_err_length;

    logic                     w_accept;
    logic                     w_col_last;
    logic                     w_line_last;
    logic [WIDTH_BITS-1:0]    w_width_eff;
    logic [HEIGHT_BITS-1:0]   w_height_eff;
    logic [GAP_BITS-1:0]      w_gap_eff;
    logic [c_DW-1:0]          w_sum_add;
    logic [9:0]               w_line_code;
    logic                     w_set_uf;
    logic                     w_set_el;

    assign w_accept     = s_tvalid & r_ready;
    assign w_col_last   = (r_col == (r_width - c_W_ONE));
    assign w_line_last  = (r_line == (r_height - c_H_ONE));
    assign w_width_eff  = (param_width < c_W_TWO) ? c_W_TWO : param_width;
    assign w_height_eff = (param_height == '0) ? c_H_ONE : param_height;
    assign w_gap_eff    = (param_gap == '0) ? c_G_ONE : param_gap;

    // Per-lane 10-bit wrapping accumulation of the accepted word
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane_sum
            assign w_sum_add[10*gi +: 10] = r_sum[10*gi +: 10] + s_tdata[10*gi +: 10];
        end
    endgenerate

    always_comb begin
        w_line_code = CODE_IMG;
        if (r_col == '0) begin
            w_line_code = (r_line == '0) ? CODE_FS : CODE_LS;
        end else if (w_col_last) begin
            w_line_code = w_line_last ? CODE_FE : CODE_LE;
        end
    end

    // Frame-start word is column 0 of a line at least 2 wide, so tlast there is always wrong
    assign w_set_uf = (r_state == ST_LINE) && !s_tvalid;
    assign w_set_el = w_accept &&
                      (((r_state == ST_LINE) && (s_tlast != w_col_last)) ||
                       ((r_state == ST_IDLE) && s_tuser && s_tlast));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_col        <= '0;
            r_line       <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_sum        <= '0;
            r_out_data   <= c_TR_ALL;
            r_out_sync   <= CODE_TR;
            r_underflow  <= 1'b0;
            r_err_length <= 1'b0;
        end else begin
            r_underflow  <= w_set_uf | (r_underflow & ~err_clear);
            r_err_length <= w_set_el | (r_err_length & ~err_clear);

            case (r_state)
                ST_IDLE: begin
                    r_out_data <= c_TR_ALL;
                    r_out_sync <= CODE_TR;
                    r_ready    <= 1'b1;
                    if (w_accept && s_tuser) begin
                        r_width    <= w_width_eff;
                        r_height   <= w_height_eff;
                        r_gap      <= w_gap_eff;
                        r_line     <= '0;
                        r_col      <= c_W_ONE;
                        r_sum      <= w_sum_add;
                        r_out_data <= s_tdata;
                        r_out_sync <= CODE_FS;
                        r_state    <= ST_LINE;
                    end
                end

                ST_LINE: begin
                    if (w_accept) begin
                        r_out_data <= s_tdata;
                        r_out_sync <= w_line_code;
                        r_sum      <= w_sum_add;
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_ready <= 1'b0;
                            r_state <= ST_CRC;
                        end else begin
                            r_col   <= r_col + c_W_ONE;
                        end
                    end else begin
                        r_out_data <= c_TR_ALL;
                        r_out_sync <= CODE_TR;
                    end
                end

                ST_CRC: begin
                    r_out_data <= r_sum;
                    r_out_sync <= CODE_CRC;
                    r_sum      <= '0;
                    r_gap_cnt  <= r_gap - c_G_ONE;
                    r_ready    <= 1'b0;
                    r_state    <= ST_GAP;
                end

                ST_GAP: begin
                    r_out_data <= c_TR_ALL;
                    r_out_sync <= CODE_TR;
                    if (r_gap_cnt == '0) begin
                        r_ready <= 1'b1;
                        if (w_line_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_line  <= r_line + c_H_ONE;
                            r_state <= ST_LINE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_G_ONE;
                        r_ready   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign s_tready   = r_ready;
    assign out_data   = r_out_data;
    assign out_sync   = r_out_sync;
    assign underflow  = r_underflow;
    assign err_length = r_err_length;

endmodule
`default_nettype wire
